// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES state enum, permutation/S-box tables and helper functions
package des_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_DEC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Tables use DES numbering: entry value 1 is the most-significant input bit.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // Each S-box is 64 nibbles in row-major order (row = {b1,b6}, column = b2..b5).
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[63-k] = x[64-IP_T[k]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[63-k] = x[64-FP_T[k]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[55-k] = x[64-PC1_T[k]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[47-k] = x[56-PC2_T[k]];
    return y;
  endfunction

  // Round function: expand, mix subkey, S-box substitute, permute.
  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int          idx;
    for (int j = 0; j < 48; j++) e[47-j] = r[32-E_T[j]];
    e = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = e[47-6*i -: 6];
      idx = {26'd0, b[5], b[0], b[4:1]};
      s[31-4*i -: 4] = SBOX[i][255-4*idx -: 4];
    end
    for (int j = 0; j < 32; j++) p[31-j] = s[32-P_T[j]];
    return p;
  endfunction

  // Rotate both 28-bit key halves left (encrypt schedule) or right (decrypt schedule).
  function automatic logic [55:0] cd_rol(input logic [55:0] cd, input logic two);
    if (two) return {cd[53:28], cd[55:54], cd[25:0], cd[27:26]};
    return {cd[54:28], cd[55], cd[26:0], cd[27]};
  endfunction

  function automatic logic [55:0] cd_ror(input logic [55:0] cd, input logic two);
    if (two) return {cd[29:28], cd[55:30], cd[1:0], cd[27:2]};
    return {cd[28], cd[55:29], cd[0], cd[27:1]};
  endfunction

  // Active-low {g,f,e,d,c,b,a} segment pattern for one hex digit.
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/des_core.sv
// rtl/des_core.sv - iterative DES engine, one round per clock, 16-cycle start-to-done
module des_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        done
);

  logic [31:0] r_l, r_r;
  logic [55:0] r_cd;
  logic [3:0]  r_round;
  logic        r_busy, r_dec, r_done;
  logic [63:0] r_dout;

  logic [55:0] w_cd_enc, w_cd_next;
  logic [47:0] w_subkey;
  logic [31:0] w_r_new;
  logic        w_two_enc, w_two_dec;

  // Key schedule step: encrypt rotates before use, decrypt uses then rotates back.
  always_comb begin
    w_two_enc = !(r_round == 4'd0 || r_round == 4'd1 || r_round == 4'd8  || r_round == 4'd15);
    w_two_dec = !(r_round == 4'd0 || r_round == 4'd7 || r_round == 4'd14 || r_round == 4'd15);
    w_cd_enc  = cd_rol(r_cd, w_two_enc);
    if (r_dec) begin
      w_subkey  = perm_pc2(r_cd);
      w_cd_next = cd_ror(r_cd, w_two_dec);
    end else begin
      w_subkey  = perm_pc2(w_cd_enc);
      w_cd_next = w_cd_enc;
    end
    w_r_new = r_l ^ feistel(r_r, w_subkey);
  end

  // Load on start, then run 16 rounds; the last round registers the swapped, FP'd block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_l <= '0; r_r <= '0; r_cd <= '0; r_round <= '0;
      r_busy <= 1'b0; r_dec <= 1'b0; r_done <= 1'b0; r_dout <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        {r_l, r_r} <= perm_ip(din);
        r_cd       <= perm_pc1(key);
        r_round    <= '0;
        r_busy     <= 1'b1;
        r_dec      <= decrypt;
      end else if (r_busy) begin
        r_l     <= r_r;
        r_r     <= w_r_new;
        r_cd    <= w_cd_next;
        r_round <= r_round + 4'd1;
        if (r_round == 4'd15) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_dout <= perm_fp({w_r_new, r_r});
        end
      end
    end
  end

  assign dout = r_dout;
  assign done = r_done;

endmodule

// File: rtl/des_wrapper.sv
// rtl/des_wrapper.sv - DES known-answer demo top; optional CIPHER_CHECK_EN drives LEDR[15]
module des_wrapper
  import des_pkg::*;
#(
  parameter logic [63:0] MSG_INIT = 64'h0123456789ABCDEF,
  parameter logic [63:0] KEY_INIT = 64'h133457799BBCDFF1
) (
  input  logic        clk,
  input  logic [3:0]  KEY,
  input  logic [15:0] SW,
  output logic [17:0] LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

`ifdef CIPHER_CHECK_EN
  localparam logic [63:0] CIPH_EXP = 64'h85E813540F0AB405;
`endif

  state_t      r_state, w_next;
  logic [63:0] r_cipher_q, r_plain_q;
  logic        w_rst_n, w_start, w_decrypt, w_done;
  logic [63:0] w_din, w_dout;
  logic [31:0] w_disp;
  logic        w_unused;

  assign w_rst_n  = KEY[0];
  assign w_unused = ^{KEY[3:1], SW[15:6]};

  // State register.
  always_ff @(posedge clk) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Sequencing: start encrypt from IDLE, chain decrypt of the ciphertext on encrypt done.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_decrypt = 1'b0;
    w_din     = MSG_INIT;
    case (r_state)
      S_IDLE: begin
        w_start = 1'b1;
        w_next  = S_ENC;
      end
      S_ENC: if (w_done) begin
        w_start   = 1'b1;
        w_decrypt = 1'b1;
        w_din     = w_dout;
        w_next    = S_DEC;
      end
      S_DEC:   if (w_done) w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the core result belonging to each phase.
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      r_cipher_q <= '0;
      r_plain_q  <= '0;
    end else if (w_done) begin
      if (r_state == S_ENC) r_cipher_q <= w_dout;
      if (r_state == S_DEC) r_plain_q  <= w_dout;
    end
  end

  des_core u_core (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .start   (w_start),
    .decrypt (w_decrypt),
    .key     (KEY_INIT),
    .din     (w_din),
    .dout    (w_dout),
    .done    (w_done)
  );

  // Display word: lowest set select bit wins.
  always_comb begin
    w_disp = 32'h0;
    if      (SW[0]) w_disp = MSG_INIT[63:32];
    else if (SW[1]) w_disp = MSG_INIT[31:0];
    else if (SW[2]) w_disp = KEY_INIT[31:0];
    else if (SW[3]) w_disp = r_cipher_q[31:0];
    else if (SW[4]) w_disp = r_cipher_q[63:32];
    else if (SW[5]) w_disp = r_plain_q[31:0];
  end

  // Status LEDs.
  always_comb begin
    LEDR      = '0;
    LEDR[17]  = (r_state == S_DONE);
    LEDR[16]  = (r_state == S_DONE) && (r_plain_q == MSG_INIT);
`ifdef CIPHER_CHECK_EN
    LEDR[15]  = (r_cipher_q == CIPH_EXP) && (r_state == S_DEC || r_state == S_DONE);
`else
    LEDR[15]  = 1'b0;
`endif
    LEDR[1:0] = r_state;
  end

  assign HEX0 = hex7seg(w_disp[3:0]);
  assign HEX1 = hex7seg(w_disp[7:4]);
  assign HEX2 = hex7seg(w_disp[11:8]);
  assign HEX3 = hex7seg(w_disp[15:12]);
  assign HEX4 = hex7seg(w_disp[19:16]);
  assign HEX5 = hex7seg(w_disp[23:20]);
  assign HEX6 = hex7seg(w_disp[27:24]);
  assign HEX7 = hex7seg(w_disp[31:28]);

endmodule

// File: tb/tb_des_wrapper.sv
// tb/tb_des_wrapper.sv - directed self-checking bench for des_wrapper with a display scoreboard
module tb_des_wrapper;

  logic        clk = 1'b0;
  logic [3:0]  KEY = 4'b0000;
  logic [15:0] SW  = 16'h0000;
  logic [17:0] LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

`ifdef CIPHER_CHECK_EN
  localparam logic [17:0] CC = 18'h08000;
`else
  localparam logic [17:0] CC = 18'h00000;
`endif
  localparam logic [17:0] LED_ENC  = 18'h00001;
  localparam logic [17:0] LED_DEC  = 18'h00002 | CC;
  localparam logic [17:0] LED_DONE = 18'h30003 | CC;

  always #5 clk = ~clk;

  des_wrapper dut (
    .clk(clk), .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive SW, queue the expected word, then compare the eight digits.
  task automatic show(input string tag, input logic [15:0] sw, input logic [31:0] word);
    logic [31:0] e;
    logic [55:0] exp_seg;
    SW = sw;
    exp_q.push_back(word);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < 8; i++) exp_seg[7*i +: 7] = seg(e[4*i +: 4]);
      check(tag, {8'h0, HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {8'h0, exp_seg});
    end
  endtask

  initial begin
    int n;
    // Step 1: reset held for two edges.
    KEY = 4'b0000; SW = 16'h0002;
    tick(); tick();
    check("reset_ledr", LEDR, 18'h0);
    show("reset_msg_lo", 16'h0002, 32'h89ABCDEF);
    show("reset_cipher", 16'h0008, 32'h0);
    show("reset_plain", 16'h0020, 32'h0);

    // Step 2: release and run the encrypt phase.
    KEY = 4'b0001;
    tick();
    check("enc_state", LEDR, LED_ENC);
    for (int i = 0; i < 19; i++) tick();
    check("dec_state_20", LEDR, LED_DEC);
    show("cipher_lo", 16'h0008, 32'h0F0AB405);
    // Step 3.
    show("cipher_hi", 16'h0010, 32'h85E81354);

    // Step 4: full sequence done by 40 cycles.
    for (int i = 0; i < 20; i++) tick();
    check("done_ledr", LEDR, LED_DONE);
    show("plain_lo", 16'h0020, 32'h89ABCDEF);

    // Step 5: remaining selects and priority.
    show("key_lo", 16'h0004, 32'h9BBCDFF1);
    show("none_sel", 16'h0000, 32'h0);
    show("prio_sw1", 16'h0006, 32'h89ABCDEF);
    show("msg_hi", 16'h0001, 32'h01234567);
    show("upper_ignored", 16'hFFC0, 32'h0);
    show("prio_sw3", 16'h0038, 32'h0F0AB405);

    // Step 6: reset from DONE clears captures, then abort during ENC and re-run.
    KEY = 4'b0000;
    tick();
    check("rst2_ledr", LEDR, 18'h0);
    show("rst2_cipher", 16'h0010, 32'h0);
    KEY = 4'b0001;
    tick();
    check("rerun_enc", LEDR, LED_ENC);
    for (int i = 0; i < 5; i++) tick();
    KEY = 4'b0000;
    tick();
    check("abort_idle", LEDR, 18'h0);
    show("abort_cipher", 16'h0008, 32'h0);
    KEY = 4'b0001;
    n = 0;
    while (!LEDR[17] && n < 60) begin
      tick();
      n++;
    end
    check("rerun_done_by_40", {63'd0, (n <= 40)}, 64'd1);
    check("rerun_ledr", LEDR, LED_DONE);
    show("rerun_cipher_lo", 16'h0008, 32'h0F0AB405);
    show("rerun_cipher_hi", 16'h0010, 32'h85E81354);
    show("rerun_plain", 16'h0020, 32'h89ABCDEF);
    tick(); tick();
    check("done_holds", LEDR, LED_DONE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
